// File: rtl/game_pkg.sv
// Shared types and default constants for the game round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    ADVANCE    = 3'd2,
    ROUND_END  = 3'd3,
    GAME_OVER  = 3'd4
  } game_state_t;

  localparam int DEF_SCREEN_WIDTH             = 1280;
  localparam int DEF_SCREEN_HEIGHT            = 720;
  localparam int DEF_GOAL_DEPTH               = 60;
  localparam int DEF_GOAL_DEPTH_DELTA         = 10;
  localparam int DEF_MAX_WALL_DEPTH           = 75;
  localparam int DEF_NUM_WALLS                = 10;
  localparam int DEF_NUM_LIVES                = 3;
  localparam int DEF_COUNTDOWN_FRAMES         = 90;
  localparam int DEF_COLLISION_THRESHOLD      = 64;
  localparam int DEF_MAX_FRAMES_PER_WALL_TICK = 15;
  localparam int DEF_MIN_FRAMES_PER_WALL_TICK = 3;
  localparam int DEF_ROUNDS_PER_SPEEDUP       = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/game_round_controller_if.sv
// Incoming pixel stream: raster position, valid strobe and the person/wall masks for that pixel.
interface game_round_controller_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        data_valid;
  logic        is_person;
  logic        is_wall;

  modport master (output hcount, vcount, data_valid, is_person, is_wall);
  modport slave  (input  hcount, vcount, data_valid, is_person, is_wall);
endinterface

// File: rtl/frame_tick_gen.sv
// Divides frame events by a run-time count: tick fires on the advance that reaches max_count.
module frame_tick_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] max_count,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;

  assign tick = advance && (cnt == max_count);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/game_round_controller.sv
// Round/lives/score controller for a wall-dodging game, driven by the video pixel stream.
// Collisions inside the judging depth window cost at most one life per round.
module game_round_controller
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH             = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT            = DEF_SCREEN_HEIGHT,
  parameter int GOAL_DEPTH               = DEF_GOAL_DEPTH,
  parameter int GOAL_DEPTH_DELTA         = DEF_GOAL_DEPTH_DELTA,
  parameter int MAX_WALL_DEPTH           = DEF_MAX_WALL_DEPTH,
  parameter int NUM_WALLS                = DEF_NUM_WALLS,
  parameter int NUM_LIVES                = DEF_NUM_LIVES,
  parameter int COUNTDOWN_FRAMES         = DEF_COUNTDOWN_FRAMES,
  parameter int COLLISION_THRESHOLD      = DEF_COLLISION_THRESHOLD,
  parameter int MAX_FRAMES_PER_WALL_TICK = DEF_MAX_FRAMES_PER_WALL_TICK,
  parameter int MIN_FRAMES_PER_WALL_TICK = DEF_MIN_FRAMES_PER_WALL_TICK,
  parameter int ROUNDS_PER_SPEEDUP       = DEF_ROUNDS_PER_SPEEDUP
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             start_game_in,
  game_round_controller_if.slave           pix,
  output logic [10:0]                      hcount_out,
  output logic [9:0]                       vcount_out,
  output logic                             data_valid_out,
  output logic                             is_collision_out,
  output logic [$clog2(NUM_WALLS)-1:0]     wall_idx_out,
  output logic [7:0]                       wall_depth_out,
  output logic [7:0]                       score_out,
  output logic [$clog2(NUM_LIVES+1)-1:0]   lives_out,
  output game_state_t                      game_state_out,
  output logic                             hit_pulse_out
);
  localparam int WALL_W  = $clog2(NUM_WALLS);
  localparam int LIVES_W = $clog2(NUM_LIVES + 1);
  localparam int CD_W    = (COUNTDOWN_FRAMES > 1) ? $clog2(COUNTDOWN_FRAMES) : 1;
  localparam int SPD_W   = (ROUNDS_PER_SPEEDUP > 1) ? $clog2(ROUNDS_PER_SPEEDUP) : 1;
  // One spare bit keeps the saturation value strictly above the threshold.
  localparam int COLL_W  = $clog2(COLLISION_THRESHOLD + 2) + 1;
  localparam int WIN_LO  = GOAL_DEPTH - GOAL_DEPTH_DELTA;
  localparam int WIN_HI  = GOAL_DEPTH + GOAL_DEPTH_DELTA;

  game_state_t       state, state_d;
  logic [7:0]        depth, depth_d;
  logic [7:0]        score, score_d;
  logic [7:0]        fpt, fpt_d;
  logic [WALL_W-1:0] wall_idx, wall_idx_d;
  logic [LIVES_W-1:0] lives, lives_d;
  logic [CD_W-1:0]   cd_cnt, cd_cnt_d;
  logic [SPD_W-1:0]  spd_cnt, spd_cnt_d;
  logic [COLL_W-1:0] coll_cnt, coll_cnt_d;
  logic              round_hit, round_hit_d;
  logic              hit_pulse, hit_pulse_d;

  logic              new_frame, collision, advancing, in_window, tick, hit;
  logic [COLL_W:0]   judge_cnt;

  assign new_frame = pix.data_valid
                  && (pix.hcount == 11'(SCREEN_WIDTH - 1))
                  && (pix.vcount == 10'(SCREEN_HEIGHT - 1));
  assign collision = pix.data_valid && pix.is_person && pix.is_wall;
  assign advancing = (state == ADVANCE);
  assign in_window = (int'(depth) >= WIN_LO) && (int'(depth) <= WIN_HI);

  // The frame's last pixel is judged together with everything accumulated before it.
  assign judge_cnt = {1'b0, coll_cnt} + (COLL_W+1)'(collision && in_window);
  assign hit       = advancing && new_frame && !round_hit
                  && (int'(judge_cnt) > COLLISION_THRESHOLD);

  frame_tick_gen #(
    .CNT_W (8)
  ) u_frame_tick_gen (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clear     (!advancing),
    .advance   (advancing && new_frame),
    .max_count (fpt - 8'd1),
    .tick      (tick)
  );

  // Per-frame collision count; anything outside ADVANCE discards a partial frame.
  always_comb begin
    coll_cnt_d = coll_cnt;
    if (new_frame || !advancing) begin
      coll_cnt_d = '0;
    end else if (in_window && collision && (coll_cnt != '1)) begin
      coll_cnt_d = coll_cnt + 1'b1;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    depth_d     = depth;
    score_d     = score;
    fpt_d       = fpt;
    wall_idx_d  = wall_idx;
    lives_d     = lives;
    cd_cnt_d    = cd_cnt;
    spd_cnt_d   = spd_cnt;
    round_hit_d = round_hit;
    hit_pulse_d = 1'b0;

    unique case (state)
      IDLE, GAME_OVER: begin
        if (start_game_in) begin
          state_d     = COUNTDOWN;
          score_d     = '0;
          lives_d     = LIVES_W'(NUM_LIVES);
          wall_idx_d  = '0;
          depth_d     = '0;
          fpt_d       = 8'(MAX_FRAMES_PER_WALL_TICK);
          round_hit_d = 1'b0;
          cd_cnt_d    = '0;
          spd_cnt_d   = '0;
        end
      end

      COUNTDOWN: begin
        if (new_frame) begin
          if (cd_cnt == CD_W'(COUNTDOWN_FRAMES - 1)) begin
            cd_cnt_d = '0;
            state_d  = ADVANCE;
          end else begin
            cd_cnt_d = cd_cnt + 1'b1;
          end
        end
      end

      ADVANCE: begin
        if (hit) begin
          lives_d     = lives - 1'b1;
          round_hit_d = 1'b1;
          hit_pulse_d = 1'b1;
        end
        // A fatal hit wins over a coinciding depth tick; the wall freezes where it is.
        if (hit && (lives == LIVES_W'(1))) begin
          state_d = GAME_OVER;
        end else if (tick) begin
          if (depth == 8'(MAX_WALL_DEPTH - 1)) begin
            depth_d = '0;
            state_d = ROUND_END;
          end else begin
            depth_d = depth + 8'd1;
          end
        end
      end

      ROUND_END: begin
        if (!round_hit) begin
          score_d = sat_inc8(score);
        end
        wall_idx_d  = (wall_idx == WALL_W'(NUM_WALLS - 1)) ? '0 : wall_idx + 1'b1;
        round_hit_d = 1'b0;
        state_d     = COUNTDOWN;
        if (spd_cnt == SPD_W'(ROUNDS_PER_SPEEDUP - 1)) begin
          spd_cnt_d = '0;
          if (fpt > 8'(MIN_FRAMES_PER_WALL_TICK)) begin
            fpt_d = fpt - 8'd1;
          end
        end else begin
          spd_cnt_d = spd_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      depth     <= '0;
      score     <= '0;
      fpt       <= 8'(MAX_FRAMES_PER_WALL_TICK);
      wall_idx  <= '0;
      lives     <= '0;
      cd_cnt    <= '0;
      spd_cnt   <= '0;
      coll_cnt  <= '0;
      round_hit <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      state     <= state_d;
      depth     <= depth_d;
      score     <= score_d;
      fpt       <= fpt_d;
      wall_idx  <= wall_idx_d;
      lives     <= lives_d;
      cd_cnt    <= cd_cnt_d;
      spd_cnt   <= spd_cnt_d;
      coll_cnt  <= coll_cnt_d;
      round_hit <= round_hit_d;
      hit_pulse <= hit_pulse_d;
    end
  end

  // Pixel stream delayed one cycle, independent of game state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_out       <= '0;
      vcount_out       <= '0;
      data_valid_out   <= 1'b0;
      is_collision_out <= 1'b0;
    end else begin
      hcount_out       <= pix.hcount;
      vcount_out       <= pix.vcount;
      data_valid_out   <= pix.data_valid;
      is_collision_out <= collision;
    end
  end

  assign wall_idx_out   = wall_idx;
  assign wall_depth_out = depth;
  assign score_out      = score;
  assign lives_out      = lives;
  assign game_state_out = state;
  assign hit_pulse_out  = hit_pulse;

endmodule

// File: tb/tb_game_round_controller.sv
// Randomized scoreboard bench for game_round_controller on a shrunken screen and round.
// The reference model tracks the game in plain integers; a monitor compares every cycle.
module tb_game_round_controller;
  import game_pkg::*;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int GD     = 5;
  localparam int GDD    = 2;
  localparam int MWD    = 10;
  localparam int NW     = 3;
  localparam int NL     = 3;
  localparam int CDF    = 2;
  localparam int THR    = 10;
  localparam int MAXF   = 4;
  localparam int MINF   = 2;
  localparam int RPS    = 2;
  localparam int FRAMES = 1300;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic start_game_in;
  logic rst_req;

  game_round_controller_if pix ();

  logic [10:0]             hcount_out;
  logic [9:0]              vcount_out;
  logic                    data_valid_out;
  logic                    is_collision_out;
  logic [$clog2(NW)-1:0]   wall_idx_out;
  logic [7:0]              wall_depth_out;
  logic [7:0]              score_out;
  logic [$clog2(NL+1)-1:0] lives_out;
  game_state_t             game_state_out;
  logic                    hit_pulse_out;

  always #5 clk_in = ~clk_in;

  game_round_controller #(
    .SCREEN_WIDTH             (W),
    .SCREEN_HEIGHT            (H),
    .GOAL_DEPTH               (GD),
    .GOAL_DEPTH_DELTA         (GDD),
    .MAX_WALL_DEPTH           (MWD),
    .NUM_WALLS                (NW),
    .NUM_LIVES                (NL),
    .COUNTDOWN_FRAMES         (CDF),
    .COLLISION_THRESHOLD      (THR),
    .MAX_FRAMES_PER_WALL_TICK (MAXF),
    .MIN_FRAMES_PER_WALL_TICK (MINF),
    .ROUNDS_PER_SPEEDUP       (RPS)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_game_in    (start_game_in),
    .pix              (pix),
    .hcount_out       (hcount_out),
    .vcount_out       (vcount_out),
    .data_valid_out   (data_valid_out),
    .is_collision_out (is_collision_out),
    .wall_idx_out     (wall_idx_out),
    .wall_depth_out   (wall_depth_out),
    .score_out        (score_out),
    .lives_out        (lives_out),
    .game_state_out   (game_state_out),
    .hit_pulse_out    (hit_pulse_out)
  );

  typedef struct {
    int h, v, dv, coll, st, wall, depth, score, lives, hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model of the game, in integers.
  game_state_t m_st;
  int m_score, m_lives, m_wall, m_depth, m_rounds, m_frames, m_cd, m_hits, m_round_hit;
  bit round_attack;
  bit reset_done;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model_fpt(input int rounds);
    int f;
    f = MAXF - rounds / RPS;
    return (f < MINF) ? MINF : f;
  endfunction

  task automatic model_reset();
    m_st = IDLE;
    m_score = 0; m_lives = 0; m_wall = 0; m_depth = 0; m_rounds = 0;
    m_frames = 0; m_cd = 0; m_hits = 0; m_round_hit = 0;
  endtask

  task automatic model_step(input int h, input int v, input int dv, input int p, input int w,
                            input int st_in, input int rst, output exp_t e);
    bit nf, coll, in_win;
    nf     = (dv != 0) && (h == W - 1) && (v == H - 1);
    coll   = (dv != 0) && (p != 0) && (w != 0);
    in_win = (m_depth >= GD - GDD) && (m_depth <= GD + GDD);
    e.hit  = 0;
    if (rst == 0) begin
      model_reset();
      nf = 0; coll = 0; h = 0; v = 0; dv = 0;
    end else begin
      case (m_st)
        IDLE, GAME_OVER: begin
          if (st_in != 0) begin
            m_st = COUNTDOWN;
            m_score = 0; m_lives = NL; m_wall = 0; m_depth = 0;
            m_rounds = 0; m_cd = 0; m_round_hit = 0;
          end
        end
        COUNTDOWN: begin
          if (nf) begin
            m_cd++;
            if (m_cd == CDF) begin
              m_cd = 0; m_frames = 0; m_hits = 0; m_st = ADVANCE;
            end
          end
        end
        ADVANCE: begin
          if (in_win && coll) m_hits++;
          if (nf) begin
            if (m_hits > THR && m_round_hit == 0) begin
              m_lives--; m_round_hit = 1; e.hit = 1;
            end
            m_hits = 0;
            if (m_lives == 0) begin
              m_st = GAME_OVER;
            end else begin
              m_frames++;
              if (m_frames == model_fpt(m_rounds)) begin
                m_frames = 0;
                if (m_depth == MWD - 1) begin
                  m_depth = 0; m_st = ROUND_END;
                end else begin
                  m_depth++;
                end
              end
            end
          end
        end
        ROUND_END: begin
          if (m_round_hit == 0) m_score = (m_score >= 255) ? 255 : m_score + 1;
          m_wall = (m_wall + 1) % NW;
          m_round_hit = 0;
          m_rounds++;
          m_st = COUNTDOWN;
        end
        default: m_st = IDLE;
      endcase
    end
    e.h = h; e.v = v; e.dv = dv; e.coll = int'(coll);
    e.st = int'(m_st); e.wall = m_wall; e.depth = m_depth;
    e.score = m_score; e.lives = m_lives;
  endtask

  task automatic drive(input int h, input int v, input int dv, input int p, input int w,
                       input int st);
    exp_t e;
    @(negedge clk_in);
    rst_n_in          = rst_req;
    pix.hcount        = 11'(h);
    pix.vcount        = 10'(v);
    pix.data_valid    = (dv != 0);
    pix.is_person     = (p != 0);
    pix.is_wall       = (w != 0);
    start_game_in     = (st != 0);
    model_step(h, v, dv, p, w, st, int'(rst_req), e);
    exp_q.push_back(e);
  endtask

  function automatic int start_bit();
    if (m_st == IDLE || m_st == GAME_OVER) return int'($urandom_range(0, 49) == 0);
    return int'($urandom_range(0, 63) == 0);
  endfunction

  task automatic check_reset_outputs();
    check("rst_hcount", int'(hcount_out), 0);
    check("rst_vcount", int'(vcount_out), 0);
    check("rst_valid", int'(data_valid_out), 0);
    check("rst_collision", int'(is_collision_out), 0);
    check("rst_wall_idx", int'(wall_idx_out), 0);
    check("rst_depth", int'(wall_depth_out), 0);
    check("rst_score", int'(score_out), 0);
    check("rst_lives", int'(lives_out), 0);
    check("rst_state", int'(game_state_out), int'(IDLE));
    check("rst_hit_pulse", int'(hit_pulse_out), 0);
  endtask

  // One frame of pixels with random idle gaps; collisions are packed at the frame's end.
  task automatic run_frame(input int f, input int reset_idx);
    int n_coll, r, idx, p, w, k;
    bit in_win, last_tick, cl;
    if (m_st != ADVANCE) round_attack = ($urandom_range(0, 99) < 35);
    in_win    = (m_st == ADVANCE) && (m_depth >= GD - GDD) && (m_depth <= GD + GDD);
    last_tick = (m_st == ADVANCE) && (m_depth == MWD - 1) && (m_frames == model_fpt(m_rounds) - 1);
    r = $urandom_range(0, 99);
    if (f < 50)                                n_coll = 0;
    else if (round_attack && last_tick && r < 60) n_coll = THR + 1;
    else if (r < 40)                           n_coll = 0;
    else if (r < 55)                           n_coll = THR;
    else if (r < 75)                           n_coll = -1;
    else if (!in_win || round_attack)          n_coll = $urandom_range(THR + 1, W * H);
    else                                       n_coll = THR;

    for (int v = 0; v < H; v++) begin
      for (int h = 0; h < W; h++) begin
        idx = v * W + h;
        if (idx == reset_idx) begin
          @(negedge clk_in);
          rst_req  = 1'b0;
          rst_n_in = 1'b0;
          #1;
          check_reset_outputs();
          model_reset();
          drive(h, v, 1, 1, 1, 0);
          drive(h, v, 1, 1, 1, 1);
          rst_req = 1'b1;
        end
        while ($urandom_range(0, 7) == 0) begin
          drive($urandom_range(0, W - 1), $urandom_range(0, H - 1), 0,
                $urandom_range(0, 1), $urandom_range(0, 1), start_bit());
        end
        if (n_coll < 0) cl = ($urandom_range(0, 7) == 0);
        else            cl = (idx >= W * H - n_coll);
        if (cl) begin
          p = 1; w = 1;
        end else begin
          k = $urandom_range(0, 2);
          p = int'(k == 1);
          w = int'(k == 2);
        end
        drive(h, v, 1, p, w, start_bit());
      end
    end
  endtask

  // Monitor: one expectation per clock, compared after the edge has settled.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk_in);
      #2;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("hcount_out", int'(hcount_out), mon_e.h);
        check("vcount_out", int'(vcount_out), mon_e.v);
        check("data_valid_out", int'(data_valid_out), mon_e.dv);
        check("is_collision_out", int'(is_collision_out), mon_e.coll);
        check("game_state_out", int'(game_state_out), mon_e.st);
        check("wall_idx_out", int'(wall_idx_out), mon_e.wall);
        check("wall_depth_out", int'(wall_depth_out), mon_e.depth);
        check("score_out", int'(score_out), mon_e.score);
        check("lives_out", int'(lives_out), mon_e.lives);
        check("hit_pulse_out", int'(hit_pulse_out), mon_e.hit);
      end
    end
  end

  int reset_at;
  initial begin
    rst_req        = 1'b0;
    rst_n_in       = 1'b0;
    start_game_in  = 1'b0;
    pix.hcount     = '0;
    pix.vcount     = '0;
    pix.data_valid = 1'b0;
    pix.is_person  = 1'b0;
    pix.is_wall    = 1'b0;
    round_attack   = 1'b0;
    reset_done     = 1'b0;
    model_reset();

    // Reset held while a start request and a full frame corner are presented.
    drive(W - 1, H - 1, 1, 1, 1, 1);
    drive(W - 1, H - 1, 1, 1, 1, 1);
    #1;
    check_reset_outputs();

    rst_req = 1'b1;
    drive(0, 0, 0, 0, 0, 1);

    for (int f = 0; f < FRAMES; f++) begin
      reset_at = -1;
      if (!reset_done && f >= FRAMES / 2 && m_st == ADVANCE) begin
        reset_at   = (W * H) / 2;
        reset_done = 1'b1;
      end
      run_frame(f, reset_at);
    end

    repeat (3) @(posedge clk_in);
    #3;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
